// File: rtl/traffic_light_monitor_if.sv
// Lamp bus between the two-street controller and its safety monitor.
// The monitor takes the slave side; the controller or a test driver takes the master side.
interface traffic_light_monitor_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       la;
    logic [2:0]       lb;
    logic             clear;
    logic             fault;
    logic [2:0]       fault_code;
    logic             force_red;
    logic [2:0]       phase;
    logic             phase_valid;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output la, lb, clear,
        input  fault, fault_code, force_red, phase, phase_valid, cycle_cnt
    );

    modport slave (
        input  la, lb, clear,
        output fault, fault_code, force_red, phase, phase_valid, cycle_cnt
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Lamp-bus safety monitor: rebuilds the 8-phase cycle and latches the first rule violation.
// Lamp words are registered, then judged on the following edge (2-edge latency); no backpressure.
module traffic_light_monitor #(
    parameter int MIN_ALLRED = 1,
    parameter int YEL_MAX    = 1,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    traffic_light_monitor_if.slave bus
);
    localparam logic [2:0] RED = 3'b111;
    localparam logic [2:0] YEL = 3'b100;
    localparam logic [2:0] GRN = 3'b110;

    localparam int AR_W = $clog2(MIN_ALLRED + 2);
    localparam int YC_W = $clog2(YEL_MAX + 2);
    localparam logic [AR_W-1:0] AR_MAX  = AR_W'(MIN_ALLRED);
    localparam logic [YC_W-1:0] YEL_LIM = YC_W'(YEL_MAX);
    localparam logic [YC_W-1:0] YEL_SAT = YC_W'(YEL_MAX + 1);

    typedef enum logic [1:0] {SYNC, RUN, FAULT} state_t;

    state_t           state;
    logic [2:0]       cur_a, cur_b, prev_a, prev_b;
    logic             cur_vld, prev_vld;
    logic [AR_W-1:0]  allred_cnt;
    logic [YC_W-1:0]  yel_a, yel_b;
    logic             grn_hist_a, grn_hist_b, owner_b;
    logic             fault_q, pv_q;
    logic [2:0]       code_q, phase_q;
    logic [CNT_W-1:0] cnt_q;

    logic       a_red, b_red, a_ok, b_ok;
    logic       c_bad, c_conf, c_seq, c_short, c_yel;
    logic       basic_en, full_en;
    logic [2:0] new_code, dec_phase;

    always_comb begin
        a_red   = (cur_a == RED);
        b_red   = (cur_b == RED);
        a_ok    = (cur_a inside {RED, YEL, GRN});
        b_ok    = (cur_b inside {RED, YEL, GRN});
        c_bad   = cur_vld && !(a_ok && b_ok);
        c_conf  = cur_vld && !a_red && !b_red;
        c_seq   = cur_vld && prev_vld &&
                  ((prev_a == GRN && cur_a == RED) || (prev_a == RED && cur_a == GRN) ||
                   (prev_b == GRN && cur_b == RED) || (prev_b == RED && cur_b == GRN));
        c_short = cur_vld && prev_vld && (allred_cnt < AR_MAX) &&
                  ((prev_a == RED && !a_red) || (prev_b == RED && !b_red));
        c_yel   = cur_vld && ((cur_a == YEL && yel_a >= YEL_LIM) ||
                              (cur_b == YEL && yel_b >= YEL_LIM));
        // A clear out of FAULT restarts in SYNC, so only sample-local rules apply there.
        basic_en = (state != FAULT) || bus.clear;
        full_en  = (state == RUN);
    end

    always_comb begin
        new_code = 3'd0;
        if (basic_en && c_bad)        new_code = 3'd1;
        else if (basic_en && c_conf)  new_code = 3'd2;
        else if (full_en && c_seq)    new_code = 3'd3;
        else if (full_en && c_short)  new_code = 3'd4;
        else if (full_en && c_yel)    new_code = 3'd5;
    end

    always_comb begin
        dec_phase = 3'd2;
        if (cur_a == GRN)                     dec_phase = 3'd0;
        else if (cur_b == GRN)                dec_phase = 3'd4;
        else if (cur_a == YEL)                dec_phase = grn_hist_a ? 3'd1 : 3'd7;
        else if (cur_b == YEL)                dec_phase = grn_hist_b ? 3'd5 : 3'd3;
        else if (state == RUN && owner_b)     dec_phase = 3'd6;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SYNC;
            cur_a      <= 3'd0;
            cur_b      <= 3'd0;
            prev_a     <= 3'd0;
            prev_b     <= 3'd0;
            cur_vld    <= 1'b0;
            prev_vld   <= 1'b0;
            allred_cnt <= AR_MAX;
            yel_a      <= '0;
            yel_b      <= '0;
            grn_hist_a <= 1'b0;
            grn_hist_b <= 1'b0;
            owner_b    <= 1'b0;
            fault_q    <= 1'b0;
            code_q     <= 3'd0;
            phase_q    <= 3'd0;
            pv_q       <= 1'b0;
            cnt_q      <= '0;
        end else begin
            cur_a    <= bus.la;
            cur_b    <= bus.lb;
            cur_vld  <= 1'b1;
            prev_a   <= cur_a;
            prev_b   <= cur_b;
            prev_vld <= cur_vld && !bus.clear;

            if (cur_vld) begin
                if (a_red && b_red)
                    allred_cnt <= (allred_cnt == AR_MAX) ? allred_cnt : allred_cnt + 1'b1;
                else
                    allred_cnt <= '0;
                yel_a <= (cur_a != YEL) ? '0 : (yel_a == YEL_SAT) ? yel_a : yel_a + 1'b1;
                yel_b <= (cur_b != YEL) ? '0 : (yel_b == YEL_SAT) ? yel_b : yel_b + 1'b1;
                // Yellow direction depends on the colour held before the yellow began.
                if (cur_a != YEL) grn_hist_a <= (cur_a == GRN);
                if (cur_b != YEL) grn_hist_b <= (cur_b == GRN);
                if (!a_red || !b_red) owner_b <= !b_red;
            end

            if (new_code != 3'd0) begin
                state   <= FAULT;
                fault_q <= 1'b1;
                code_q  <= new_code;
                pv_q    <= 1'b0;
            end else if (bus.clear) begin
                state   <= SYNC;
                fault_q <= 1'b0;
                code_q  <= 3'd0;
                pv_q    <= 1'b0;
            end else begin
                case (state)
                    SYNC: if (cur_vld) begin
                        state   <= RUN;
                        pv_q    <= 1'b1;
                        phase_q <= dec_phase;
                    end
                    RUN: begin
                        phase_q <= dec_phase;
                        if (phase_q == 3'd7 && dec_phase == 3'd0) cnt_q <= cnt_q + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.fault       = fault_q;
    assign bus.force_red   = fault_q;
    assign bus.fault_code  = code_q;
    assign bus.phase       = phase_q;
    assign bus.phase_valid = pv_q;
    assign bus.cycle_cnt   = cnt_q;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: table of lamp samples plus short all-red and reset sequences.
module tb_traffic_light_monitor;
    localparam logic [2:0] R  = 3'b111;
    localparam logic [2:0] Y  = 3'b100;
    localparam logic [2:0] G  = 3'b110;
    localparam logic [2:0] BD = 3'b010;
    localparam int NV = 33;

    typedef struct packed {
        logic [2:0]  la;
        logic [2:0]  lb;
        logic        clr;
        logic        f;
        logic [2:0]  code;
        logic [2:0]  ph;
        logic        pv;
        logic [15:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic reset2;
    int   checks = 0;
    int   errors = 0;
    vec_t v [NV];

    always #5 clk = ~clk;

    traffic_light_monitor_if #(.CNT_W(16)) bus ();
    traffic_light_monitor_if #(.CNT_W(16)) bus2 ();

    traffic_light_monitor #(.MIN_ALLRED(1), .YEL_MAX(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    traffic_light_monitor #(.MIN_ALLRED(2), .YEL_MAX(1), .CNT_W(16)) dut2 (
        .clk(clk), .reset(reset2), .bus(bus2)
    );

    function automatic vec_t row(input logic [2:0] la, lb, input logic clr, f,
                                 input logic [2:0] code, ph, input logic pv,
                                 input logic [15:0] cnt);
        row = '{la: la, lb: lb, clr: clr, f: f, code: code, ph: ph, pv: pv, cnt: cnt};
    endfunction

    // {fault, force_red, code, phase, phase_valid, cycle_cnt}
    function automatic logic [24:0] snap(input logic f, fr, input logic [2:0] c, p,
                                         input logic pv, input logic [15:0] cnt);
        snap = {f, fr, c, p, pv, cnt};
    endfunction

    task automatic cmp(input string name, input logic [24:0] got, input logic [24:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got fault=%0b force_red=%0b code=%0d phase=%0d pv=%0b cnt=%0d, want fault=%0b force_red=%0b code=%0d phase=%0d pv=%0b cnt=%0d",
                     name, got[24], got[23], got[22:20], got[19:17], got[16], got[15:0],
                     exp[24], exp[23], exp[22:20], exp[19:17], exp[16], exp[15:0]);
        end
    endtask

    function automatic logic [24:0] out1();
        out1 = snap(bus.fault, bus.force_red, bus.fault_code, bus.phase, bus.phase_valid, bus.cycle_cnt);
    endfunction

    function automatic logic [24:0] out2();
        out2 = snap(bus2.fault, bus2.force_red, bus2.fault_code, bus2.phase, bus2.phase_valid, bus2.cycle_cnt);
    endfunction

    task automatic step2(input logic [2:0] la, lb);
        bus2.la = la;
        bus2.lb = lb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected outputs of each row appear one edge after the row's sample is taken;
        // clr asserts clear on the edge that judges that row's sample.
        v[0]  = row(G, R, 0, 0, 0, 0, 1, 0);
        v[1]  = row(G, R, 0, 0, 0, 0, 1, 0);
        v[2]  = row(G, R, 0, 0, 0, 0, 1, 0);
        v[3]  = row(Y, R, 0, 0, 0, 1, 1, 0);
        v[4]  = row(R, R, 0, 0, 0, 2, 1, 0);
        v[5]  = row(R, Y, 0, 0, 0, 3, 1, 0);
        v[6]  = row(R, G, 0, 0, 0, 4, 1, 0);
        v[7]  = row(R, G, 0, 0, 0, 4, 1, 0);
        v[8]  = row(R, Y, 0, 0, 0, 5, 1, 0);
        v[9]  = row(R, R, 0, 0, 0, 6, 1, 0);
        v[10] = row(Y, R, 0, 0, 0, 7, 1, 0);
        v[11] = row(G, R, 0, 0, 0, 0, 1, 1);
        v[12] = row(G, G, 0, 1, 2, 0, 0, 1);
        v[13] = row(G, R, 0, 1, 2, 0, 0, 1);
        v[14] = row(G, R, 1, 0, 0, 0, 0, 1);
        v[15] = row(G, R, 0, 0, 0, 0, 1, 1);
        v[16] = row(R, R, 0, 1, 3, 0, 0, 1);
        v[17] = row(R, Y, 0, 1, 3, 0, 0, 1);
        v[18] = row(R, G, 1, 0, 0, 0, 0, 1);
        v[19] = row(R, G, 0, 0, 0, 4, 1, 1);
        v[20] = row(BD, G, 0, 1, 1, 4, 0, 1);
        v[21] = row(R, G, 0, 1, 1, 4, 0, 1);
        v[22] = row(R, G, 1, 0, 0, 4, 0, 1);
        v[23] = row(R, G, 0, 0, 0, 4, 1, 1);
        v[24] = row(R, Y, 0, 0, 0, 5, 1, 1);
        v[25] = row(R, Y, 0, 1, 5, 5, 0, 1);
        v[26] = row(G, G, 1, 1, 2, 5, 0, 1);
        v[27] = row(R, R, 1, 0, 0, 5, 0, 1);
        v[28] = row(R, R, 0, 0, 0, 2, 1, 1);
        v[29] = row(R, Y, 0, 0, 0, 3, 1, 1);
        v[30] = row(R, G, 1, 0, 0, 3, 0, 1);
        v[31] = row(R, G, 0, 0, 0, 4, 1, 1);
        v[32] = row(G, G, 0, 1, 2, 4, 0, 1);

        reset = 1'b1;
        reset2 = 1'b1;
        bus.la = R;  bus.lb = R;  bus.clear = 1'b0;
        bus2.la = R; bus2.lb = R; bus2.clear = 1'b0;
        #12;
        cmp("reset_state", out1(), snap(0, 0, 0, 0, 0, 0));
        cmp("reset_state2", out2(), snap(0, 0, 0, 0, 0, 0));

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NV; i++) begin
            bus.la = v[i].la;
            bus.lb = v[i].lb;
            bus.clear = (i > 0) ? v[i-1].clr : 1'b0;
            @(posedge clk);
            #1;
            if (i > 0)
                cmp($sformatf("row%0d", i - 1), out1(),
                    snap(v[i-1].f, v[i-1].f, v[i-1].code, v[i-1].ph, v[i-1].pv, v[i-1].cnt));
        end
        bus.clear = v[NV-1].clr;
        @(posedge clk);
        #1;
        cmp($sformatf("row%0d", NV - 1), out1(),
            snap(v[NV-1].f, v[NV-1].f, v[NV-1].code, v[NV-1].ph, v[NV-1].pv, v[NV-1].cnt));

        // Asynchronous reset between edges with a fault and a nonzero cycle count latched.
        #2;
        reset = 1'b1;
        #1;
        cmp("async_reset", out1(), snap(0, 0, 0, 0, 0, 0));

        // MIN_ALLRED=2 instance: two all-red samples pass, a single one faults.
        @(negedge clk);
        reset2 = 1'b0;
        step2(G, R);
        step2(G, R);
        step2(Y, R);
        step2(R, R);
        step2(R, R);
        step2(R, Y);
        step2(R, G);
        cmp("allred_two_ok", out2(), snap(0, 0, 0, 3, 1, 0));
        step2(R, Y);
        cmp("allred_b_grn", out2(), snap(0, 0, 0, 4, 1, 0));
        step2(R, R);
        step2(Y, R);
        cmp("allred_b_done", out2(), snap(0, 0, 0, 6, 1, 0));
        step2(G, R);
        cmp("allred_short", out2(), snap(1, 1, 4, 6, 0, 0));
        step2(G, R);
        cmp("allred_short_held", out2(), snap(1, 1, 4, 6, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
